// File: rtl/mips_avalon_arbiter_if.sv
// CPU-side request channels plus the shared Avalon-MM master bus of the arbiter.
// master: the arbiter's view; slave: the CPU/interconnect environment's view.
interface mips_avalon_arbiter_if #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [N_PORTS-1:0]        port_read;
  logic [N_PORTS-1:0]        port_write;
  logic [N_PORTS*ADDR_W-1:0] port_address;
  logic [N_PORTS*DATA_W-1:0] port_writedata;
  logic [N_PORTS*BE_W-1:0]   port_byteenable;
  logic [N_PORTS*DATA_W-1:0] port_readdata;
  logic [N_PORTS-1:0]        port_ack;

  logic                      waitrequest;
  logic [DATA_W-1:0]         readdata;
  logic                      read;
  logic                      write;
  logic [ADDR_W-1:0]         address;
  logic [DATA_W-1:0]         writedata;
  logic [BE_W-1:0]           byteenable;
  logic                      busy;

  modport master (
    input  port_read, port_write, port_address, port_writedata, port_byteenable,
    input  waitrequest, readdata,
    output port_readdata, port_ack,
    output read, write, address, writedata, byteenable, busy
  );

  modport slave (
    output port_read, port_write, port_address, port_writedata, port_byteenable,
    output waitrequest, readdata,
    input  port_readdata, port_ack,
    input  read, write, address, writedata, byteenable, busy
  );
endinterface

// File: rtl/mips_avalon_arbiter.sv
// N-port Avalon-MM master front-end: fixed-priority or round-robin arbitration,
// with an optional per-port single-entry read-hold register tagged by address.
module mips_avalon_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter bit          RR_MODE = 1'b0,
  parameter bit          HOLD_EN = 1'b1
) (
  input logic                   clk,
  input logic                   reset_n,
  mips_avalon_arbiter_if.master bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [DATA_W-1:0]  writedata_q, writedata_d;
  logic [BE_W-1:0]    byteenable_q, byteenable_d;
  logic [N_PORTS-1:0] port_ack_q, port_ack_d;
  logic               busy_q, busy_d;
  logic [N_PORTS-1:0] hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0]  hold_tag_q  [N_PORTS];
  logic [ADDR_W-1:0]  hold_tag_d  [N_PORTS];
  logic [DATA_W-1:0]  hold_data_q [N_PORTS];
  logic [DATA_W-1:0]  hold_data_d [N_PORTS];

  logic [ADDR_W-1:0]  p_addr  [N_PORTS];
  logic [DATA_W-1:0]  p_wdata [N_PORTS];
  logic [BE_W-1:0]    p_be    [N_PORTS];
  logic [N_PORTS-1:0] req_c;
  logic [N_PORTS-1:0] inval_c;
  logic               pick_valid_c;
  logic [IDX_W-1:0]   pick_c;
  logic               pick_wr_c;
  logic               hit_c;

  // Unpack per-port buses; a write invalidates any hold entry in the same word.
  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign p_addr[g]  = bus.port_address[g*ADDR_W +: ADDR_W];
    assign p_wdata[g] = bus.port_writedata[g*DATA_W +: DATA_W];
    assign p_be[g]    = bus.port_byteenable[g*BE_W +: BE_W];
    assign inval_c[g] = (hold_tag_q[g][ADDR_W-1:2] == address_q[ADDR_W-1:2]);
    assign bus.port_readdata[g*DATA_W +: DATA_W] = hold_data_q[g];
  end

  assign req_c = bus.port_read | bus.port_write;

  // Scan eligible ports starting at 0 (fixed) or one past the last grant (round-robin).
  always_comb begin : arbitrate
    int unsigned        idx;
    logic [N_PORTS-1:0] sel;
    idx          = 0;
    sel          = '0;
    pick_valid_c = 1'b0;
    pick_c       = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (RR_MODE) begin
        idx = (32'(last_grant_q) + 32'd1 + k) % N_PORTS;
      end else begin
        idx = k;
      end
      sel = req_c >> idx;
      if (!pick_valid_c && sel[0]) begin
        pick_valid_c = 1'b1;
        pick_c       = IDX_W'(idx);
      end
    end
  end

  // A write wins over a simultaneous read on the same port, so only pure reads can hit.
  assign pick_wr_c = bus.port_write[pick_c];
  assign hit_c     = HOLD_EN && !pick_wr_c && hold_valid_q[pick_c] &&
                     (hold_tag_q[pick_c] == p_addr[pick_c]);

  always_comb begin : next_state
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    port_ack_d   = '0;
    hold_valid_d = hold_valid_q;
    hold_tag_d   = hold_tag_q;
    hold_data_d  = hold_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          grant_d      = pick_c;
          last_grant_d = pick_c;
          if (hit_c) begin
            port_ack_d = N_PORTS'(1) << pick_c;
            state_d    = ST_DONE;
          end else begin
            address_d    = p_addr[pick_c];
            writedata_d  = p_wdata[pick_c];
            byteenable_d = pick_wr_c ? p_be[pick_c] : '1;
            write_d      = pick_wr_c;
            read_d       = !pick_wr_c;
            state_d      = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!bus.waitrequest) begin
          read_d     = 1'b0;
          write_d    = 1'b0;
          port_ack_d = N_PORTS'(1) << grant_q;
          state_d    = ST_DONE;
          if (read_q) begin
            hold_data_d[grant_q]  = bus.readdata;
            hold_tag_d[grant_q]   = address_q;
            hold_valid_d[grant_q] = 1'b1;
          end else begin
            hold_valid_d = hold_valid_q & ~inval_c;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      port_ack_q   <= '0;
      busy_q       <= 1'b0;
      hold_valid_q <= '0;
      hold_tag_q   <= '{default: '0};
      hold_data_q  <= '{default: '0};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      port_ack_q   <= port_ack_d;
      busy_q       <= busy_d;
      hold_valid_q <= hold_valid_d;
      hold_tag_q   <= hold_tag_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = byteenable_q;
  assign bus.port_ack   = port_ack_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Bench for mips_avalon_arbiter: a fixed-priority/hold instance is checked against a
// transaction-level model; a round-robin/no-hold twin sees the same stimulus.
module tb_mips_avalon_arbiter;
  localparam int unsigned N_PORTS = 2;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = DATA_W / 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_avalon_arbiter_if #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) fp_if ();
  mips_avalon_arbiter_if #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) rr_if ();

  mips_avalon_arbiter #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .RR_MODE(1'b0), .HOLD_EN(1'b1))
    dut_fp (.clk(clk), .reset_n(reset_n), .bus(fp_if.master));

  mips_avalon_arbiter #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .RR_MODE(1'b1), .HOLD_EN(1'b0))
    dut_rr (.clk(clk), .reset_n(reset_n), .bus(rr_if.master));

  assign rr_if.port_read       = fp_if.port_read;
  assign rr_if.port_write      = fp_if.port_write;
  assign rr_if.port_address    = fp_if.port_address;
  assign rr_if.port_writedata  = fp_if.port_writedata;
  assign rr_if.port_byteenable = fp_if.port_byteenable;
  assign rr_if.waitrequest     = fp_if.waitrequest;
  assign rr_if.readdata        = fp_if.readdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model of the fixed-priority instance's hold registers.
  bit          m_valid [N_PORTS];
  logic [31:0] m_tag   [N_PORTS];
  logic [31:0] m_data  [N_PORTS];

  function automatic bit m_hit(input int p, input bit wr, input logic [31:0] a);
    return !wr && m_valid[p] && (m_tag[p] == a);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_PORTS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
  endtask

  task automatic m_complete(input int p, input bit hit, input bit wr,
                            input logic [31:0] a, input logic [31:0] rd);
    if (wr) begin
      for (int q = 0; q < N_PORTS; q++)
        if ((m_tag[q] >> 2) == (a >> 2)) m_valid[q] = 1'b0;
    end else if (!hit) begin
      m_valid[p] = 1'b1;
      m_tag[p]   = a;
      m_data[p]  = rd;
    end
  endtask

  task automatic set_port(input int p, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    fp_if.port_read[p]                        = rd;
    fp_if.port_write[p]                       = wr;
    fp_if.port_address[p*ADDR_W +: ADDR_W]    = a;
    fp_if.port_writedata[p*DATA_W +: DATA_W]  = wd;
    fp_if.port_byteenable[p*BE_W +: BE_W]     = be;
  endtask

  function automatic logic [31:0] rdata_of(input int p);
    return fp_if.port_readdata[p*DATA_W +: DATA_W];
  endfunction

  task automatic apply_reset();
    reset_n               = 1'b0;
    fp_if.port_read       = '0;
    fp_if.port_write      = '0;
    fp_if.port_address    = '0;
    fp_if.port_writedata  = '0;
    fp_if.port_byteenable = '0;
    fp_if.waitrequest     = 1'b0;
    fp_if.readdata        = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    m_reset();
  endtask

  // Called at a negedge of an IDLE cycle with the request already driven (cycle 0).
  task automatic run_txn(input int p, input bit exp_hit, input bit exp_wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input int waits, input logic [31:0] rd, input string name);
    logic [N_PORTS-1:0] exp_ack;
    logic [3:0]         exp_be;
    exp_ack = N_PORTS'(1) << p;
    exp_be  = exp_wr ? be : 4'hF;
    fp_if.readdata = rd;
    @(negedge clk);
    if (exp_hit) begin
      n_checks++;
      if (fp_if.port_ack !== exp_ack || fp_if.read !== 1'b0 || fp_if.write !== 1'b0 ||
          rdata_of(p) !== m_data[p])
        $display("FAIL %s hit: ack=%b rd=%b wr=%b data=%h, want ack=%b no strobe data=%h",
                 name, fp_if.port_ack, fp_if.read, fp_if.write, rdata_of(p), exp_ack, m_data[p]);
      else n_pass++;
    end else begin
      n_checks++;
      if (fp_if.read !== !exp_wr || fp_if.write !== exp_wr || fp_if.address !== a ||
          fp_if.byteenable !== exp_be || (exp_wr && fp_if.writedata !== wd) ||
          fp_if.port_ack !== '0 || fp_if.busy !== 1'b1)
        $display("FAIL %s strobe: rd=%b wr=%b addr=%h wd=%h be=%h ack=%b, want rd=%b wr=%b addr=%h wd=%h be=%h",
                 name, fp_if.read, fp_if.write, fp_if.address, fp_if.writedata, fp_if.byteenable,
                 fp_if.port_ack, !exp_wr, exp_wr, a, wd, exp_be);
      else n_pass++;
      fp_if.waitrequest = (waits > 0);
      for (int k = 0; k < waits; k++) begin
        @(negedge clk);
        n_checks++;
        if (fp_if.read !== !exp_wr || fp_if.write !== exp_wr || fp_if.address !== a ||
            fp_if.byteenable !== exp_be || (exp_wr && fp_if.writedata !== wd) ||
            fp_if.port_ack !== '0)
          $display("FAIL %s wait%0d: rd=%b wr=%b addr=%h wd=%h be=%h ack=%b, want held bus and no ack",
                   name, k, fp_if.read, fp_if.write, fp_if.address, fp_if.writedata,
                   fp_if.byteenable, fp_if.port_ack);
        else n_pass++;
        if (k == waits - 1) fp_if.waitrequest = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (fp_if.port_ack !== exp_ack || fp_if.read !== 1'b0 || fp_if.write !== 1'b0 ||
          fp_if.busy !== 1'b1)
        $display("FAIL %s done: ack=%b rd=%b wr=%b busy=%b, want ack=%b rd=0 wr=0 busy=1",
                 name, fp_if.port_ack, fp_if.read, fp_if.write, fp_if.busy, exp_ack);
      else n_pass++;
      if (!exp_wr) begin
        n_checks++;
        if (rdata_of(p) !== rd)
          $display("FAIL %s readdata: got %h want %h", name, rdata_of(p), rd);
        else n_pass++;
      end
    end
    set_port(p, 1'b0, 1'b0, a, wd, be);
    m_complete(p, exp_hit, exp_wr, a, rd);
    @(negedge clk);
    n_checks++;
    if (fp_if.port_ack !== '0 || fp_if.busy !== 1'b0 || fp_if.read !== 1'b0 || fp_if.write !== 1'b0)
      $display("FAIL %s idle: ack=%b busy=%b rd=%b wr=%b, want all 0",
               name, fp_if.port_ack, fp_if.busy, fp_if.read, fp_if.write);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    fp_if.port_read = '0;
    fp_if.port_write = '0;
    fp_if.waitrequest = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fp_if.read !== 1'b0 || fp_if.write !== 1'b0 || fp_if.address !== '0 ||
        fp_if.writedata !== '0 || fp_if.byteenable !== '0 || fp_if.port_ack !== '0 ||
        fp_if.busy !== 1'b0 || fp_if.port_readdata !== '0)
      $display("FAIL reset_state: rd=%b wr=%b addr=%h wd=%h be=%h ack=%b busy=%b pdata=%h, want all 0",
               fp_if.read, fp_if.write, fp_if.address, fp_if.writedata, fp_if.byteenable,
               fp_if.port_ack, fp_if.busy, fp_if.port_readdata);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_single_miss();
    apply_reset();
    set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    run_txn(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hDEADBEEF, "single_miss");
    @(negedge clk);
    n_checks++;
    if (rdata_of(0) !== 32'hDEADBEEF)
      $display("FAIL readdata_held: got %h want DEADBEEF", rdata_of(0));
    else n_pass++;
  endtask

  task automatic test_hold_invalidate();
    apply_reset();
    set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    run_txn(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hDEADBEEF, "hold_fill");
    set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    run_txn(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h11111111, "hold_hit");
    set_port(1, 1'b0, 1'b1, 32'h102, 32'h0BADF00D, 4'hF);
    run_txn(1, 1'b0, 1'b1, 32'h102, 32'h0BADF00D, 4'hF, 0, 32'h0, "inval_write");
    n_checks++;
    if (rdata_of(0) !== 32'hDEADBEEF)
      $display("FAIL hold_stable_after_write: got %h want DEADBEEF", rdata_of(0));
    else n_pass++;
    set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    run_txn(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h12345678, "reread_after_inval");
  endtask

  task automatic test_hold_disabled();
    apply_reset();
    for (int t = 0; t < 2; t++) begin
      fp_if.readdata = (t == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
      set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      @(negedge clk);
      n_checks++;
      if (rr_if.read !== 1'b1 || rr_if.address !== 32'h100)
        $display("FAIL nohold_strobe%0d: rd=%b addr=%h want rd=1 addr=00000100", t, rr_if.read, rr_if.address);
      else n_pass++;
      @(negedge clk);
      set_port(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
      @(negedge clk);
      n_checks++;
      if (rr_if.port_readdata[DATA_W-1:0] !== fp_if.readdata)
        $display("FAIL nohold_data%0d: got %h want %h", t, rr_if.port_readdata[DATA_W-1:0], fp_if.readdata);
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    apply_reset();
    set_port(0, 1'b0, 1'b1, 32'h20, 32'h55AA, 4'h3);
    run_txn(0, 1'b0, 1'b1, 32'h20, 32'h55AA, 4'h3, 4, 32'h0, "wait_states");
  endtask

  task automatic test_arbitration();
    int          fp_g[$];
    int          fp_c[$];
    int          rr_g[$];
    logic [31:0] next_a;
    apply_reset();
    next_a = 32'h1000;
    set_port(0, 1'b1, 1'b0, 32'h0800, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 32'h0900, 32'h0, 4'h0);
    for (int c = 0; c < 40 && (fp_g.size() < 4 || rr_g.size() < 4); c++) begin
      @(negedge clk);
      if (fp_if.port_ack !== '0) begin
        fp_g.push_back(fp_if.port_ack[1] ? 1 : 0);
        fp_c.push_back(c);
      end
      if (rr_if.port_ack !== '0) rr_g.push_back(rr_if.port_ack[1] ? 1 : 0);
      for (int p = 0; p < N_PORTS; p++) begin
        if (fp_if.port_ack[p] || rr_if.port_ack[p]) begin
          next_a = next_a + 32'h10;
          set_port(p, 1'b1, 1'b0, next_a, 32'h0, 4'h0);
        end
      end
    end
    fp_if.port_read = '0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= fp_g.size() || fp_g[i] != 0)
        $display("FAIL fixed_grant%0d: got %0d (of %0d grants) want 0", i,
                 (i < fp_g.size()) ? fp_g[i] : -1, fp_g.size());
      else n_pass++;
      n_checks++;
      if (i >= rr_g.size() || rr_g[i] != (i % 2))
        $display("FAIL rr_grant%0d: got %0d (of %0d grants) want %0d", i,
                 (i < rr_g.size()) ? rr_g[i] : -1, rr_g.size(), i % 2);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i + 1 >= fp_c.size() || fp_c[i+1] - fp_c[i] != 3)
        $display("FAIL back_to_back%0d: spacing %0d want 3", i,
                 (i + 1 < fp_c.size()) ? fp_c[i+1] - fp_c[i] : -1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    run_txn(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hCAFE0001, "pre_reset_fill");
    set_port(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    fp_if.waitrequest = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fp_if.read !== 1'b1)
      $display("FAIL mid_access_strobe: rd=%b want 1", fp_if.read);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (fp_if.read !== 1'b0 || fp_if.port_ack !== '0 || fp_if.busy !== 1'b0 || rdata_of(0) !== '0)
      $display("FAIL async_reset: rd=%b ack=%b busy=%b pdata=%h, want all 0",
               fp_if.read, fp_if.port_ack, fp_if.busy, rdata_of(0));
    else n_pass++;
    set_port(0, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    fp_if.waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    @(negedge clk);
    n_checks++;
    if (fp_if.port_ack !== '0 || fp_if.read !== 1'b0)
      $display("FAIL abandoned_ack: ack=%b rd=%b want 0", fp_if.port_ack, fp_if.read);
    else n_pass++;
    set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    run_txn(0, m_hit(0, 1'b0, 32'h100), 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hCAFE0002, "post_reset_read");
  endtask

  task automatic test_read_write_same_port();
    apply_reset();
    set_port(1, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hC);
    run_txn(1, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hC, 2, 32'h77777777, "rd_wr_same_port");
    @(negedge clk);
    n_checks++;
    if (fp_if.port_ack !== '0 || fp_if.read !== 1'b0 || fp_if.write !== 1'b0)
      $display("FAIL rd_wr_single: ack=%b rd=%b wr=%b want all 0", fp_if.port_ack, fp_if.read, fp_if.write);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] pool [5];
    bit          rd [N_PORTS];
    bit          wr [N_PORTS];
    logic [31:0] a  [N_PORTS];
    logic [31:0] wd [N_PORTS];
    logic [3:0]  be [N_PORTS];
    int          mask;
    int          op;
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h102; pool[3] = 32'h200; pool[4] = 32'h300;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      mask = int'($urandom_range(1, 3));
      for (int p = 0; p < N_PORTS; p++) begin
        op    = int'($urandom_range(0, 19));
        rd[p] = (op < 15);
        wr[p] = (op >= 12);
        a[p]  = pool[$urandom_range(0, 4)];
        wd[p] = $urandom;
        be[p] = 4'($urandom_range(1, 15));
        if (((mask >> p) & 1) != 0) set_port(p, rd[p], wr[p], a[p], wd[p], be[p]);
        else set_port(p, 1'b0, 1'b0, a[p], wd[p], be[p]);
      end
      for (int p = 0; p < N_PORTS; p++) begin
        if (((mask >> p) & 1) != 0)
          run_txn(p, m_hit(p, wr[p], a[p]), wr[p], a[p], wd[p], be[p],
                  int'($urandom_range(0, 3)), $urandom, "random");
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_single_miss();
    test_hold_invalidate();
    test_hold_disabled();
    test_wait_states();
    test_arbitration();
    test_reset_mid_access();
    test_read_write_same_port();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
